// File: rtl/sm_fifo_wr_arb_pkg.sv
// Shared defaults and width helpers for the credit-based FIFO write arbiter.
package sm_fifo_arb_pkg;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_DW         = 8;
  localparam int DEF_FIFO_DEPTH = 5;

  // Width needed to hold 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sm_fifo_wr_arb_if.sv
// Requester / FIFO-side signal bundle of the write arbiter.
interface sm_fifo_wr_arb_if
  import sm_fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW,
  parameter int CW   = credit_width(DEF_FIFO_DEPTH)
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_data;
  logic               fifo_rd_en;
  logic               fifo_empty;
  logic [CW-1:0]      credits;

  modport master (
    input  req, req_data, fifo_rd_en, fifo_empty,
    output gnt, fifo_wr_en, fifo_data, credits
  );

  modport slave (
    output req, req_data, fifo_rd_en, fifo_empty,
    input  gnt, fifo_wr_en, fifo_data, credits
  );

endinterface

// File: rtl/sm_fifo_wr_arb_rr_pick.sv
// Combinational round-robin pick: first set req after last_winner, with wrap.
module sm_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [IW:0]     cand [NREQ];
  logic [NREQ-1:0] hit;

  // cand[gi] is the index at distance gi+1 from the last winner, reduced mod NREQ.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum       = {1'b0, last_winner} + (IW+1)'(gi + 1);
      assign cand[gi]  = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
      assign hit[gi]   = req[cand[gi][IW-1:0]];
    end
  endgenerate

  // Scan farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        winner = cand[k][IW-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm_fifo_wr_arb.sv
// Round-robin write arbiter in front of a sync FIFO; a credit counter replaces the full flag.
module sm_fifo_wr_arb
  import sm_fifo_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  sm_fifo_wr_arb_if.master bus
);

  localparam int          CW      = credit_width(FIFO_DEPTH);
  localparam int          IW      = idx_width(NREQ);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic            wr_en_reg;
  logic [DW-1:0]   data_reg, data_next;
  logic [CW-1:0]   credits_reg, credits_next;
  logic [IW-1:0]   last_reg, last_next;

  logic [DW-1:0]   data_arr [NREQ];
  logic [IW-1:0]   winner;
  logic            any_req;
  logic            issue;
  logic            pop_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign data_arr[gi] = bus.req_data[gi*DW +: DW];
    end
  endgenerate

  sm_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req         (bus.req),
    .last_winner (last_reg),
    .winner      (winner),
    .valid       (any_req)
  );

  assign issue  = any_req && (credits_reg != '0);
  assign pop_ok = bus.fifo_rd_en && !bus.fifo_empty;

  always_comb begin
    gnt_next  = '0;
    data_next = data_reg;
    last_next = last_reg;
    if (issue) begin
      gnt_next[winner] = 1'b1;
      data_next        = data_arr[winner];
      last_next        = winner;
    end
  end

  // Push and pop in the same cycle cancel; a pop at full credit is ignored.
  always_comb begin
    credits_next = credits_reg;
    if (issue && !pop_ok) begin
      credits_next = credits_reg - 1'b1;
    end else if (!issue && pop_ok && (credits_reg != DEPTH_C)) begin
      credits_next = credits_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      data_reg    <= '0;
      credits_reg <= DEPTH_C;
      last_reg    <= LAST_RST;
    end else begin
      gnt_reg     <= gnt_next;
      wr_en_reg   <= issue;
      data_reg    <= data_next;
      credits_reg <= credits_next;
      last_reg    <= last_next;
    end
  end

  assign bus.gnt        = gnt_reg;
  assign bus.fifo_wr_en = wr_en_reg;
  assign bus.fifo_data  = data_reg;
  assign bus.credits    = credits_reg;

endmodule
